// File: rtl/seq_chk_pkg.sv
// Shared types and constants for the counter-stream sequence checker.
// Holds the FSM encoding, display-select codes and uio pin layout.
package seq_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } seq_state_e;

    localparam logic [1:0] SEL_ERR  = 2'd0;
    localparam logic [1:0] SEL_EXP  = 2'd1;
    localparam logic [1:0] SEL_STAT = 2'd2;
    localparam logic [1:0] SEL_BAD  = 2'd3;

    localparam int UIO_VALID_BIT  = 0;
    localparam int UIO_CLR_BIT    = 1;
    localparam int UIO_LOCKED_BIT = 4;
    localparam int UIO_LOST_BIT   = 5;
    localparam int UIO_PULSE_BIT  = 6;
    localparam int UIO_SAT_BIT    = 7;

    localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/seq_chk_core.sv
// Sequence-tracking core: lock FSM, flywheel expected value, match/miss
// run counters and the saturating error counter.
module seq_chk_core
    import seq_chk_pkg::*;
#(
    parameter int         LOCK_CNT = 4,
    parameter int         LOSS_CNT = 8,
    parameter logic [7:0] STEP     = 8'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_i,
    input  logic       clr_i,
    input  logic [7:0] data_i,
    output seq_state_e state_o,
    output logic [7:0] expected_o,
    output logic [3:0] miss_run_o,
    output logic [7:0] err_cnt_o,
    output logic       lost_o,
    output logic       err_pulse_o,
    output logic       bad_event_o
);

    localparam logic [3:0] LOCK_LIM = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_LIM = 4'(LOSS_CNT);

    seq_state_e state_q, state_d;
    logic [7:0] expected_q, expected_d;
    logic [3:0] match_cnt_q, match_cnt_d;
    logic [3:0] miss_run_q, miss_run_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       lost_q, lost_d;
    logic       err_pulse_q, err_pulse_d;
    logic       bad_event;
    logic       hit;

    assign hit = (data_i == expected_q);

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_cnt_d = match_cnt_q;
        miss_run_d  = miss_run_q;
        err_cnt_d   = err_cnt_q;
        lost_d      = lost_q;
        err_pulse_d = 1'b0;
        bad_event   = 1'b0;
        if (valid_i) begin
            unique case (state_q)
                IDLE: begin
                    expected_d  = data_i + STEP;
                    match_cnt_d = 4'd0;
                    state_d     = SYNC;
                end
                SYNC: begin
                    if (hit) begin
                        match_cnt_d = match_cnt_q + 4'd1;
                        expected_d  = expected_q + STEP;
                        if (match_cnt_q + 4'd1 == LOCK_LIM) begin
                            state_d    = LOCKED;
                            miss_run_d = 4'd0;
                        end
                    end else begin
                        expected_d  = data_i + STEP;
                        match_cnt_d = 4'd0;
                    end
                end
                LOCKED: begin
                    expected_d = expected_q + STEP;
                    if (hit) begin
                        miss_run_d = 4'd0;
                    end else begin
                        bad_event   = 1'b1;
                        err_pulse_d = 1'b1;
                        miss_run_d  = miss_run_q + 4'd1;
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                        // Too many misses in a row: drop lock and resync on this sample.
                        if (miss_run_q + 4'd1 == LOSS_LIM) begin
                            lost_d      = 1'b1;
                            state_d     = SYNC;
                            expected_d  = data_i + STEP;
                            match_cnt_d = 4'd0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (clr_i) begin
            err_cnt_d = 8'd0;
            lost_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            expected_q  <= 8'd0;
            match_cnt_q <= 4'd0;
            miss_run_q  <= 4'd0;
            err_cnt_q   <= 8'd0;
            lost_q      <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_cnt_q <= match_cnt_d;
            miss_run_q  <= miss_run_d;
            err_cnt_q   <= err_cnt_d;
            lost_q      <= lost_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign state_o     = state_q;
    assign expected_o  = expected_q;
    assign miss_run_o  = miss_run_q;
    assign err_cnt_o   = err_cnt_q;
    assign lost_o      = lost_q;
    assign err_pulse_o = err_pulse_q;
    assign bad_event_o = bad_event;

endmodule

// File: rtl/tt_um_seq_checker.sv
// Top of the counter-stream checker: pin unpacking, display mux and the
// optional first-bad-sample capture enabled by SEQ_CHK_FIRST_BAD_EN.
module tt_um_seq_checker
    import seq_chk_pkg::*;
#(
    parameter int         LOCK_CNT = 4,
    parameter int         LOSS_CNT = 8,
    parameter logic [7:0] STEP     = 8'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    seq_state_e state;
    logic [7:0] expected;
    logic [3:0] miss_run;
    logic [7:0] err_cnt;
    logic       lost;
    logic       err_pulse;
    logic       bad_event;
    logic       locked;
    logic       clr;
    logic [7:0] first_bad;
    logic       unused_ok;

    assign clr = uio_in[UIO_CLR_BIT];

    seq_chk_core #(
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT),
        .STEP     (STEP)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_i     (uio_in[UIO_VALID_BIT]),
        .clr_i       (clr),
        .data_i      (ui_in),
        .state_o     (state),
        .expected_o  (expected),
        .miss_run_o  (miss_run),
        .err_cnt_o   (err_cnt),
        .lost_o      (lost),
        .err_pulse_o (err_pulse),
        .bad_event_o (bad_event)
    );

`ifdef SEQ_CHK_FIRST_BAD_EN
    logic [7:0] first_bad_q, first_bad_d;
    logic       first_seen_q, first_seen_d;

    // A separate seen flag is needed because a bad sample may itself be 8'h00.
    always_comb begin
        first_bad_d  = first_bad_q;
        first_seen_d = first_seen_q;
        if (bad_event && !first_seen_q) begin
            first_bad_d  = ui_in;
            first_seen_d = 1'b1;
        end
        if (clr) begin
            first_bad_d  = 8'd0;
            first_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_bad_q  <= 8'd0;
            first_seen_q <= 1'b0;
        end else begin
            first_bad_q  <= first_bad_d;
            first_seen_q <= first_seen_d;
        end
    end

    assign first_bad = first_bad_q;
    assign unused_ok = &{1'b0, ena, uio_in[7:4]};
`else
    assign first_bad = 8'h00;
    assign unused_ok = &{1'b0, ena, uio_in[7:4], bad_event};
`endif

    assign locked = (state == LOCKED);

    always_comb begin
        uo_out = 8'h00;
        unique case (uio_in[3:2])
            SEL_ERR:  uo_out = err_cnt;
            SEL_EXP:  uo_out = expected;
            SEL_STAT: uo_out = {2'(state), lost, locked, miss_run};
            SEL_BAD:  uo_out = first_bad;
            default:  uo_out = 8'h00;
        endcase
    end

    always_comb begin
        uio_out                 = 8'h00;
        uio_out[UIO_LOCKED_BIT] = locked;
        uio_out[UIO_LOST_BIT]   = lost;
        uio_out[UIO_PULSE_BIT]  = err_pulse;
        uio_out[UIO_SAT_BIT]    = (err_cnt == 8'hFF);
    end

    assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_seq_checker.sv
// Self-checking bench for tt_um_seq_checker: vector table, directed corner
// sequences and randomized traffic against a behavioural stream model.
module tb_tt_um_seq_checker;

    localparam int STEP     = 1;
    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 8;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] uiIn = 8'h00;
    logic [7:0] uioIn;
    logic [7:0] uoOut;
    logic [7:0] uioOut;
    logic [7:0] uioOe;
    logic       validTb = 1'b0;
    logic       clrTb = 1'b0;
    logic [1:0] selTb = 2'd0;

    int total = 0;
    int bad = 0;

    // Behavioural model: mode 0=idle, 1=hunting, 2=locked.
    int mMode, mExp, mMatch, mMiss, mErr, mFb;
    bit mLost, mPulse, mFbSeen;

    typedef struct {
        bit         valid;
        logic [7:0] data;
        bit         expLocked;
        bit         expPulse;
        logic [7:0] expErr;
        logic [7:0] expExpected;
    } vec_t;

    vec_t vecs[10];

    assign uioIn = {4'h0, selTb, clrTb, validTb};

    always #10 clk = ~clk;

    tt_um_seq_checker #(
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT),
        .STEP     (8'(STEP))
    ) dut (
        .clk     (clk),
        .rst_n   (rstN),
        .ena     (ena),
        .ui_in   (uiIn),
        .uio_in  (uioIn),
        .uo_out  (uoOut),
        .uio_out (uioOut),
        .uio_oe  (uioOe)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelStep(input bit r, input bit v, input bit c, input int d);
        if (!r) begin
            mMode = 0; mExp = 0; mMatch = 0; mMiss = 0; mErr = 0;
            mFb = 0; mLost = 0; mPulse = 0; mFbSeen = 0;
            return;
        end
        mPulse = 0;
        if (v) begin
            if (mMode == 0) begin
                mExp = (d + STEP) % 256;
                mMatch = 0;
                mMode = 1;
            end else if (mMode == 1) begin
                if (d == mExp) begin
                    mMatch++;
                    mExp = (mExp + STEP) % 256;
                    if (mMatch == LOCK_CNT) begin
                        mMode = 2;
                        mMiss = 0;
                    end
                end else begin
                    mExp = (d + STEP) % 256;
                    mMatch = 0;
                end
            end else begin
                if (d == mExp) begin
                    mExp = (mExp + STEP) % 256;
                    mMiss = 0;
                end else begin
                    mExp = (mExp + STEP) % 256;
                    mErr = (mErr < 255) ? mErr + 1 : 255;
                    mPulse = 1;
                    mMiss++;
                    if (!mFbSeen) begin
                        mFb = d;
                        mFbSeen = 1;
                    end
                    if (mMiss == LOSS_CNT) begin
                        mLost = 1;
                        mMode = 1;
                        mExp = (d + STEP) % 256;
                        mMatch = 0;
                    end
                end
            end
        end
        if (c) begin
            mErr = 0; mLost = 0; mFb = 0; mFbSeen = 0;
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [7:0] want[4];
        logic [7:0] wantUio;
        want[0] = 8'(mErr);
        want[1] = 8'(mExp);
        want[2] = {2'(mMode), mLost, (mMode == 2), 4'(mMiss)};
`ifdef SEQ_CHK_FIRST_BAD_EN
        want[3] = 8'(mFb);
`else
        want[3] = 8'h00;
`endif
        wantUio = {(mErr == 255), mPulse, mLost, (mMode == 2), 4'h0};
        check({tag, " uio_out"}, uioOut, wantUio);
        check({tag, " uio_oe"}, uioOe, 8'hF0);
        for (int s = 0; s < 4; s++) begin
            selTb = 2'(s);
            #1;
            check($sformatf("%s uo_out sel=%0d", tag, s), uoOut, want[s]);
        end
    endtask

    task automatic applyStimulus(input string tag, input bit r, input bit v, input bit c, input int d);
        @(negedge clk);
        rstN = r;
        validTb = v;
        clrTb = c;
        uiIn = 8'(d);
        @(posedge clk);
        modelStep(r, v, c, d);
        #1;
        checkOutput(tag);
    endtask

    task automatic lockAt(input string tag, input int start);
        for (int i = 0; i <= LOCK_CNT; i++) applyStimulus(tag, 1, 1, 0, (start + i) % 256);
    endtask

    initial begin
        vecs[0] = '{1, 8'd20, 0, 0, 8'd0, 8'd21};
        vecs[1] = '{1, 8'd21, 0, 0, 8'd0, 8'd22};
        vecs[2] = '{1, 8'd22, 0, 0, 8'd0, 8'd23};
        vecs[3] = '{1, 8'd23, 0, 0, 8'd0, 8'd24};
        vecs[4] = '{1, 8'd24, 1, 0, 8'd0, 8'd25};
        vecs[5] = '{0, 8'd77, 1, 0, 8'd0, 8'd25};
        vecs[6] = '{1, 8'd25, 1, 0, 8'd0, 8'd26};
        vecs[7] = '{1, 8'd99, 1, 1, 8'd1, 8'd27};
        vecs[8] = '{1, 8'd27, 1, 0, 8'd1, 8'd28};
        vecs[9] = '{0, 8'd28, 1, 0, 8'd1, 8'd28};

        modelStep(0, 0, 0, 0);
        applyStimulus("reset0", 0, 0, 0, 0);
        applyStimulus("reset1", 0, 1, 0, 55);

        // Lock-up, a gap, one bad sample, and pulse clearing on an idle cycle.
        for (int i = 0; i < 10; i++) begin
            applyStimulus($sformatf("vec%0d", i), 1, vecs[i].valid, 0, int'(vecs[i].data));
            check($sformatf("vec%0d locked", i), {7'd0, uioOut[4]}, {7'd0, vecs[i].expLocked});
            check($sformatf("vec%0d pulse", i), {7'd0, uioOut[6]}, {7'd0, vecs[i].expPulse});
            selTb = 2'd0;
            #1;
            check($sformatf("vec%0d err_cnt", i), uoOut, vecs[i].expErr);
            selTb = 2'd1;
            #1;
            check($sformatf("vec%0d expected", i), uoOut, vecs[i].expExpected);
        end

        // Single injected error at expected=40, then resume on the flywheel.
        applyStimulus("clr", 1, 0, 1, 0);
        for (int v = 28; v < 40; v++) applyStimulus("to40", 1, 1, 0, v);
        applyStimulus("inject99", 1, 1, 0, 99);
        check("inject pulse", {7'd0, uioOut[6]}, 8'd1);
        applyStimulus("resume41", 1, 1, 0, 41);
        check("resume pulse", {7'd0, uioOut[6]}, 8'd0);
        check("resume locked", {7'd0, uioOut[4]}, 8'd1);
`ifdef SEQ_CHK_FIRST_BAD_EN
        selTb = 2'd3;
        #1;
        check("first_bad 99", uoOut, 8'd99);
`endif

        // Wrap through 0xFF -> 0x00 while locked.
        applyStimulus("rst wrap", 0, 0, 0, 0);
        lockAt("lockF8", 8'hF8);
        for (int v = 8'hFD; v <= 8'hFD + 6; v++) applyStimulus("wrap", 1, 1, 0, v % 256);
        check("wrap locked", {7'd0, uioOut[4]}, 8'd1);
        selTb = 2'd0;
        #1;
        check("wrap err_cnt", uoOut, 8'd0);

        // Loss of lock, relock with sticky lost, then clear.
        for (int i = 0; i < LOSS_CNT; i++) applyStimulus("losebad", 1, 1, 0, (mExp + 128) % 256);
        check("lost set", {7'd0, uioOut[5]}, 8'd1);
        check("lost unlocked", {7'd0, uioOut[4]}, 8'd0);
        for (int i = 0; i < LOCK_CNT; i++) applyStimulus("relock", 1, 1, 0, mExp);
        check("relock locked", {7'd0, uioOut[4]}, 8'd1);
        check("relock lost sticky", {7'd0, uioOut[5]}, 8'd1);
        applyStimulus("clr lost", 1, 0, 1, 0);
        check("clr lost", {7'd0, uioOut[5]}, 8'd0);

        // Drive the error counter into saturation while staying locked.
        for (int k = 0; k < 43; k++) begin
            for (int i = 0; i < LOSS_CNT - 1; i++) applyStimulus("satbad", 1, 1, 0, (mExp + 7) % 256);
            applyStimulus("satgood", 1, 1, 0, mExp);
        end
        check("err_sat", {7'd0, uioOut[7]}, 8'd1);
        applyStimulus("clr+bad", 1, 1, 1, (mExp + 3) % 256);
        check("clr+bad pulse", {7'd0, uioOut[6]}, 8'd1);
        selTb = 2'd0;
        #1;
        check("clr+bad err_cnt", uoOut, 8'd0);

        // Gaps while locked, then a one-cycle reset mid-lock.
        applyStimulus("gapfix", 1, 1, 0, mExp);
        for (int i = 0; i < 6; i++) begin
            applyStimulus("gap", 1, 0, 0, $urandom_range(0, 255));
            applyStimulus("gapgood", 1, 1, 0, mExp);
        end
        applyStimulus("midreset", 0, 1, 0, mExp);
        check("midreset uio_out", uioOut, 8'h00);

        // Random traffic, mostly in-sequence.
        for (int i = 0; i < 600; i++) begin
            int d;
            d = ($urandom_range(0, 3) != 0) ? mExp : int'($urandom_range(0, 255));
            applyStimulus("rand", $urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7,
                          $urandom_range(0, 29) == 0, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
